// File: rtl/des_key_unmixer_if.sv
// Handshake bundle between the key register, the subkey generator and the DES round datapath.
//   start     : begin a schedule (controller -> generator)
//   decrypt   : 1 = issue K16..K1, 0 = K1..K16, sampled with start
//   key       : 56-bit PC-1 output, C0 = key[55:28], D0 = key[27:0]
//   key_ready : round datapath accepts the current subkey
//   subkey    : PC-2 of cd, meaningful while key_valid
//   key_valid : subkey holds the round key for round
//   round     : 0..15 transfer index in issue order
//   cd        : current {C,D} register
//   busy      : schedule in progress
//   done      : one-cycle pulse after the 16th transfer
interface des_key_unmixer_if;
  logic        start;
  logic        decrypt;
  logic [55:0] key;
  logic        key_ready;
  logic [47:0] subkey;
  logic        key_valid;
  logic [3:0]  round;
  logic [55:0] cd;
  logic        busy;
  logic        done;

  // Controller / round-datapath side.
  modport master (
    output start, decrypt, key, key_ready,
    input  subkey, key_valid, round, cd, busy, done
  );

  // Subkey generator side.
  modport slave (
    input  start, decrypt, key, key_ready,
    output subkey, key_valid, round, cd, busy, done
  );
endinterface

// File: rtl/des_key_unmixer.sv
// Sequential DES subkey generator. Issues all 16 round keys from one PC-1-permuted key, in
// forward (K1..K16, left rotations) or reverse (K16..K1, right rotations) order, one per
// valid/ready transfer.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : des_key_unmixer_if.slave (start/decrypt/key/key_ready in; subkey/key_valid/round/
//         cd/busy/done out)
module des_key_unmixer (
  input logic               clk,
  input logic               rst,
  des_key_unmixer_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;

  logic [27:0] c_q, d_q;
  logic        single_step;
  logic        xfer;

  assign c_q = cd_q[55:28];
  assign d_q = cd_q[27:0];

  // Next issued key is schedule round round_q + 2; rounds 2, 9 and 16 use a single-bit shift.
  assign single_step = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);
  assign xfer        = (state_q == StRun) && bus.key_ready;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // PC-2 with FIPS bit 1 at cd[55]; each term is cd[56 - table entry].
  function automatic logic [47:0] pc2(input logic [55:0] x);
    return {x[42], x[39], x[45], x[32], x[55], x[51],
            x[53], x[28], x[41], x[50], x[35], x[46],
            x[33], x[37], x[44], x[52], x[30], x[48],
            x[40], x[49], x[29], x[36], x[43], x[54],
            x[15], x[4],  x[25], x[19], x[9],  x[1],
            x[26], x[16], x[5],  x[11], x[23], x[8],
            x[12], x[7],  x[17], x[0],  x[22], x[3],
            x[10], x[14], x[6],  x[20], x[27], x[24]};
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cd_q    <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRun;
      StRun:  if (xfer && (round_q == 4'd15)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cd_d    = cd_q;
    round_d = round_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d  = bus.decrypt;
          round_d = 4'd0;
          // Decrypt starts at K16, whose C16D16 equals C0D0.
          cd_d    = bus.decrypt ? bus.key
                                : {rotl(bus.key[55:28], 1'b1), rotl(bus.key[27:0], 1'b1)};
        end
      end
      StRun: begin
        if (xfer) begin
          if (round_q == 4'd15) begin
            done_d = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            cd_d    = mode_q ? {rotr(c_q, single_step), rotr(d_q, single_step)}
                             : {rotl(c_q, single_step), rotl(d_q, single_step)};
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.key_valid = (state_q == StRun);
    bus.busy      = (state_q == StRun);
    bus.done      = done_q;
    bus.round     = round_q;
    bus.cd        = cd_q;
    bus.subkey    = pc2(cd_q);
  end

endmodule
